// File: rtl/srlatch_driver.sv
// srlatch_driver: set/reset sequencer for an SR latch brick with q/qb check.
// In: clk, rst, CELV/CELG/SUB, en, period, duty, pulse_len, q, qb. Out: s, r, rb, cycle_start, fault, fault_code.
module srlatch_driver #(
  parameter int CNT_W   = 8,
  parameter int PLS_W   = 4,
  parameter int CHK_DLY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             SUB,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic [PLS_W-1:0] pulse_len,
  input  logic             q,
  input  logic             qb,
  output logic             s,
  output logic             r,
  output logic             rb,
  output logic             cycle_start,
  output logic             fault,
  output logic [1:0]       fault_code
);

  typedef enum logic [2:0] {
    IDLE, SET_P, HIGH, RST_P, LOW, FAULT
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE  = 1;
  localparam logic [CNT_W-1:0] C_TWO  = 2;
  localparam logic [PLS_W:0]   L_ONE  = 1;
  localparam logic [2:0]       CHK_LD = 3'(CHK_DLY - 1);

  state_t           state, n_state;
  logic [CNT_W-1:0] cnt, n_cnt, nc;
  logic [CNT_W-1:0] p_sh, d_sh, p_in;
  logic [PLS_W:0]   l_sh, l_in, pc, n_pc;
  logic             arm, n_arm, stop, n_stop;
  logic             n_s, n_r, n_cs, do_start;
  logic             wrap, hit_d, live;
  logic             chk_act, chk_exp;
  logic [2:0]       chk_t;
  logic             chk_cancel, chk_due, chk_bad;
  logic             unused_pins;

  assign unused_pins = CELV ^ CELG ^ SUB;

  assign p_in  = (period < C_TWO) ? C_TWO : period;
  assign l_in  = (pulse_len == '0) ? L_ONE : {1'b0, pulse_len};
  assign wrap  = (cnt == p_sh - C_ONE);
  assign nc    = wrap ? '0 : cnt + C_ONE;
  // reset point only exists for 0 < D < P
  assign hit_d = (nc == d_sh) && (d_sh < p_sh) && (d_sh != '0);
  assign live  = (state != IDLE) && (state != FAULT);

  // an opposite pulse seen before the sample cycle voids the check
  assign chk_cancel = live && chk_act && (chk_exp ? r : s);
  assign chk_due    = live && chk_act && !chk_cancel && (chk_t == '0);
  assign chk_bad    = chk_due && ((q != chk_exp) || (q == qb));

  always_comb begin
    n_state  = state;
    n_cnt    = cnt;
    n_pc     = pc;
    n_arm    = 1'b0;
    n_stop   = stop;
    n_s      = 1'b0;
    n_r      = 1'b0;
    n_cs     = 1'b0;
    do_start = 1'b0;
    unique case (state)
      IDLE: begin
        n_cnt  = '0;
        n_stop = 1'b0;
        if (arm) do_start = 1'b1;
        else     n_arm = en;
      end
      SET_P: begin
        n_cnt = nc;
        if (!en) begin
          n_state = RST_P;
          n_r     = 1'b1;
          n_pc    = L_ONE;
          n_stop  = 1'b1;
        end else if (wrap) begin
          do_start = 1'b1;
        end else if (hit_d) begin
          n_state = RST_P;
          n_r     = 1'b1;
          n_pc    = L_ONE;
        end else if (pc >= l_sh) begin
          n_state = HIGH;
        end else begin
          n_s  = 1'b1;
          n_pc = pc + L_ONE;
        end
      end
      HIGH: begin
        n_cnt = nc;
        if (!en) begin
          n_state = RST_P;
          n_r     = 1'b1;
          n_pc    = L_ONE;
          n_stop  = 1'b1;
        end else if (wrap) begin
          do_start = 1'b1;
        end else if (hit_d) begin
          n_state = RST_P;
          n_r     = 1'b1;
          n_pc    = L_ONE;
        end
      end
      RST_P: begin
        n_cnt  = nc;
        n_stop = stop | !en;
        if (wrap && en && !stop) begin
          do_start = 1'b1;
        end else if (pc >= l_sh) begin
          if (stop || !en) begin
            n_state = IDLE;
            n_cnt   = '0;
            n_stop  = 1'b0;
          end else begin
            n_state = LOW;
          end
        end else begin
          n_r  = 1'b1;
          n_pc = pc + L_ONE;
        end
      end
      LOW: begin
        n_cnt = nc;
        if (!en) begin
          n_state = IDLE;
          n_cnt   = '0;
        end else if (wrap) begin
          do_start = 1'b1;
        end
      end
      FAULT: begin
        n_r = 1'b1;
      end
      default: begin
        n_state = IDLE;
        n_cnt   = '0;
      end
    endcase
    if (do_start) begin
      n_cnt   = '0;
      n_pc    = L_ONE;
      n_cs    = 1'b1;
      n_state = (duty == '0) ? RST_P : SET_P;
      n_s     = (duty != '0);
      n_r     = (duty == '0);
    end
    if (chk_bad) begin
      n_state = FAULT;
      n_s     = 1'b0;
      n_r     = 1'b1;
      n_cs    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pc          <= '0;
      p_sh        <= C_TWO;
      d_sh        <= '0;
      l_sh        <= L_ONE;
      arm         <= 1'b0;
      stop        <= 1'b0;
      s           <= 1'b0;
      r           <= 1'b1;
      rb          <= 1'b0;
      cycle_start <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= 2'b00;
      chk_act     <= 1'b0;
      chk_exp     <= 1'b0;
      chk_t       <= '0;
    end else begin
      state       <= n_state;
      cnt         <= n_cnt;
      pc          <= n_pc;
      arm         <= n_arm;
      stop        <= n_stop;
      s           <= n_s;
      r           <= n_r;
      rb          <= ~n_r;
      cycle_start <= n_cs;
      if (do_start) begin
        p_sh <= p_in;
        d_sh <= duty;
        l_sh <= l_in;
      end
      if (chk_bad) begin
        fault      <= 1'b1;
        fault_code <= (q == qb) ? 2'b10 : 2'b01;
      end
      if (!live || chk_cancel || chk_due) chk_act <= 1'b0;
      else if (chk_t != '0) chk_t <= chk_t - 3'd1;
      if (n_state != FAULT && n_state != IDLE) begin
        if (s && !n_s) begin
          chk_act <= 1'b1;
          chk_exp <= 1'b1;
          chk_t   <= CHK_LD;
        end else if (r && !n_r) begin
          chk_act <= 1'b1;
          chk_exp <= 1'b0;
          chk_t   <= CHK_LD;
        end
      end
    end
  end

endmodule

// File: tb/tb_srlatch_driver.sv
// tb_srlatch_driver: table-driven and directed checks of srlatch_driver
// against an SR latch model (ideal, stuck-low, or q==qb).
module tb_srlatch_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] period = 8'd10;
  logic [7:0] duty = 8'd4;
  logic [3:0] pulse_len = 4'd2;
  logic       q, qb;
  logic       s, r, rb, cycle_start, fault;
  logic [1:0] fault_code;
  logic       q_l = 1'b0;
  int         mode = 0;
  int         errors = 0;
  int         checks = 0;

  typedef struct {
    logic [7:0]  period;
    logic [7:0]  duty;
    logic [3:0]  plen;
    int          peff;
    int          nper;
    logic [15:0] s_mask;
    logic [15:0] r_mask;
  } vec_t;

  vec_t vecs[8];

  srlatch_driver #(.CNT_W(8), .PLS_W(4), .CHK_DLY(2)) dut (
    .clk(clk), .rst(rst),
    .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .en(en), .period(period), .duty(duty), .pulse_len(pulse_len),
    .q(q), .qb(qb),
    .s(s), .r(r), .rb(rb), .cycle_start(cycle_start),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s) q_l <= 1'b1;
    else if (r) q_l <= 1'b0;
  end

  always_comb begin
    q  = q_l;
    qb = ~q_l;
    if (mode == 1) begin
      q  = 1'b0;
      qb = 1'b1;
    end else if (mode == 2) begin
      q  = 1'b1;
      qb = 1'b1;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reset, release, enable; returns observing cnt=0 of the first period
  task automatic start_run(input logic [7:0] p, input logic [7:0] d,
                           input logic [3:0] l, input string nm);
    rst = 1'b1;
    en = 1'b0;
    period = p;
    duty = d;
    pulse_len = l;
    step;
    step;
    chk({nm, "/rst"}, {s, r, rb, cycle_start, fault, fault_code},
        7'b0100000);
    rst = 1'b0;
    step;
    chk({nm, "/release"}, {s, r, rb, cycle_start}, 4'b0010);
    en = 1'b1;
    step;
    chk({nm, "/arm"}, {s, cycle_start}, 2'b00);
    step;
    chk({nm, "/first_start"}, cycle_start, 1'b1);
  endtask

  task automatic check_periods(input int pe, input int np,
                               input logic [15:0] sm,
                               input logic [15:0] rm, input string nm);
    for (int k = 0; k < pe * np; k++) begin
      int c;
      c = k % pe;
      chk({nm, "/cyc"}, {s, r, rb, cycle_start, fault},
          {sm[c], rm[c], ~rm[c], (c == 0), 1'b0});
      chk({nm, "/excl"}, s & r, 1'b0);
      step;
    end
  endtask

  initial begin
    vecs[0] = '{8'd10, 8'd4,  4'd2, 10, 20, 16'h0003, 16'h0030};
    vecs[1] = '{8'd10, 8'd0,  4'd2, 10, 3,  16'h0000, 16'h0003};
    vecs[2] = '{8'd10, 8'd12, 4'd2, 10, 3,  16'h0003, 16'h0000};
    vecs[3] = '{8'd8,  8'd1,  4'd4, 8,  3,  16'h0001, 16'h001E};
    vecs[4] = '{8'd6,  8'd4,  4'd4, 6,  3,  16'h000F, 16'h0030};
    vecs[5] = '{8'd1,  8'd1,  4'd0, 2,  4,  16'h0001, 16'h0002};
    vecs[6] = '{8'd10, 8'd5,  4'd0, 10, 3,  16'h0001, 16'h0020};
    vecs[7] = '{8'd10, 8'd10, 4'd3, 10, 3,  16'h0007, 16'h0000};

    mode = 0;
    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      start_run(vecs[i].period, vecs[i].duty, vecs[i].plen, nm);
      check_periods(vecs[i].peff, vecs[i].nper, vecs[i].s_mask,
                    vecs[i].r_mask, nm);
    end

    // stuck-low latch: set check fails, fault at cnt 4
    for (int m = 1; m <= 2; m++) begin
      string nm;
      logic [1:0] code;
      nm = (m == 1) ? "stuck0" : "qeqqb";
      code = (m == 1) ? 2'b01 : 2'b10;
      mode = m;
      start_run(8'd10, 8'd5, 4'd2, nm);
      for (int c = 0; c < 4; c++) begin
        chk({nm, "/prefault"}, fault, 1'b0);
        step;
      end
      chk({nm, "/fault"}, {fault, fault_code, s, r, rb, cycle_start},
          {1'b1, code, 4'b0100});
      for (int c = 0; c < 12; c++) begin
        en = (c < 6) ? 1'b0 : 1'b1;
        step;
        chk({nm, "/hold"}, {fault, fault_code, s, r, cycle_start},
            {1'b1, code, 3'b010});
      end
      rst = 1'b1;
      step;
      chk({nm, "/clear"}, {fault, fault_code, r}, 4'b0001);
      mode = 0;
    end

    // enable drop in HIGH, then re-enable with new shadows
    start_run(8'd10, 8'd8, 4'd3, "endrop");
    for (int c = 0; c < 3; c++) begin
      chk("endrop/set", {s, r}, 2'b10);
      step;
    end
    chk("endrop/high", {s, r}, 2'b00);
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step;
      chk("endrop/rpulse", {s, r, rb}, 3'b010);
    end
    for (int c = 0; c < 10; c++) begin
      step;
      chk("endrop/idle", {s, r, rb, cycle_start, fault}, 5'b00100);
    end
    period = 8'd5;
    duty = 8'd2;
    pulse_len = 4'd1;
    en = 1'b1;
    step;
    chk("reen/arm", cycle_start, 1'b0);
    step;
    check_periods(5, 3, 16'h0001, 16'h0004, "reen");

    // reset asserted in the middle of a set pulse
    start_run(8'd10, 8'd4, 4'd3, "rstmid");
    step;
    chk("rstmid/cnt1", {s, r}, 2'b10);
    rst = 1'b1;
    en = 1'b0;
    step;
    chk("rstmid/inrst", {s, r, rb, fault, cycle_start}, 5'b01000);
    rst = 1'b0;
    step;
    chk("rstmid/release", {s, r, rb}, 3'b001);
    for (int c = 0; c < 8; c++) begin
      step;
      chk("rstmid/idle", {s, r, cycle_start}, 3'b000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
